// File: rtl/load_store_unit.sv
// RV32I load/store unit: one req/ack memory access per op, 2 cycles minimum (start edge -> done pulse), +1 per memory wait cycle.
// Backpressure: start is ignored while busy. Define LSU_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rf_write_enable,
  output logic [4:0]  rf_addr_3,
  output logic [31:0] rf_write_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [31:0] ea_q;
  logic [2:0]  f3_q;
  logic        st_q;
  logic [4:0]  rd_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        fault_q;
  logic [31:0] rdata_q;
  logic [7:0]  cnt;

  logic [31:0] ea_n;
  logic [31:0] sd_rep;
  logic [3:0]  strb_n;
  logic        illegal;
  logic        misalign;

  assign ea_n = base + offset;

  assign illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                   (is_store && funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) && ea_n[0]) ||
                    ((funct3[1:0] == 2'b10) && (ea_n[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Store data is lane-replicated at accept time so the bus value is stable for the whole access.
  always_comb begin
    sd_rep = store_data;
    strb_n = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        sd_rep = {4{store_data[7:0]}};
        strb_n = 4'b0001 << ea_n[1:0];
      end
      2'b01: begin
        sd_rep = {2{store_data[15:0]}};
        strb_n = 4'b0011 << {ea_n[1], 1'b0};
      end
      default: begin
        sd_rep = store_data;
        strb_n = 4'b1111;
      end
    endcase
    if (!is_store) begin
      strb_n = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      ea_q    <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ea_q    <= ea_n;
            f3_q    <= funct3;
            st_q    <= is_store;
            rd_q    <= rd;
            wdata_q <= sd_rep;
            wstrb_q <= strb_n;
            cnt     <= '0;
            if (illegal || misalign) begin
              fault_q <= 1'b1;
              state   <= S_RESP;
            end else begin
              fault_q <= 1'b0;
              state   <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // Ack takes priority over a timeout in the same cycle.
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            fault_q <= 1'b0;
            state   <= S_RESP;
          end else if (cnt == TO_LAST) begin
            fault_q <= 1'b1;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign ld_byte = rdata_q[{ea_q[1:0], 3'b000} +: 8];
  assign ld_half = rdata_q[{ea_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  logic in_access;
  logic in_resp;

  assign in_access = (state == S_ACCESS);
  assign in_resp   = (state == S_RESP);

  assign busy      = (state != S_IDLE);
  assign done      = in_resp;
  assign fault     = in_resp && fault_q;
  assign mem_req   = in_access;
  assign mem_we    = in_access && st_q;
  assign mem_addr  = in_access ? {ea_q[31:2], 2'b00} : 32'd0;
  assign mem_wstrb = (in_access && st_q) ? wstrb_q : 4'd0;
  assign mem_wdata = (in_access && st_q) ? wdata_q : 32'd0;

  assign rf_write_enable = in_resp && !fault_q && !st_q && (rd_q != 5'd0);
  assign rf_addr_3       = rf_write_enable ? rd_q : 5'd0;
  assign rf_write_data   = rf_write_enable ? ld_ext : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a four-cycle memory timeout.
module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        rf_write_enable;
  logic [4:0]  rf_addr_3;
  logic [31:0] rf_write_data;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store),
    .funct3(funct3), .base(base), .offset(offset), .store_data(store_data),
    .rd(rd), .busy(busy), .done(done), .fault(fault), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_write_enable(rf_write_enable), .rf_addr_3(rf_addr_3),
    .rf_write_data(rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rf_model [32];
  always @(posedge clk) begin
    if (rf_write_enable) rf_model[rf_addr_3] <= rf_write_data;
  end

  typedef struct {
    logic        fault;
    logic        rfwe;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        we;
    int          req;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  int          obs_req, obs_lat, obs_rfwe;
  logic        obs_done, obs_fault, obs_we;
  logic [31:0] obs_addr, obs_wdata, obs_rf_data;
  logic [3:0]  obs_wstrb;
  logic [4:0]  obs_rf_addr;

  function automatic exp_t mk(logic f, logic w, logic [4:0] r, logic [31:0] d,
                              logic [31:0] a, logic [3:0] s, logic [31:0] wd,
                              logic we, int rq, int lt);
    exp_t x;
    x.fault = f; x.rfwe = w; x.rd = r; x.data = d; x.addr = a;
    x.wstrb = s; x.wdata = wd; x.we = we; x.req = rq; x.lat = lt;
    return x;
  endfunction

  // Drives one operation and records what the DUT did; ack_at=0 means never ack.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] b,
                        input logic [31:0] o, input logic [31:0] sd, input logic [4:0] r,
                        input logic [31:0] rdat, input int ack_at);
    obs_req = 0; obs_lat = 0; obs_rfwe = 0; obs_done = 1'b0; obs_fault = 1'b0;
    obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; obs_wstrb = '0;
    obs_rf_addr = '0; obs_rf_data = '0;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; base = b; offset = o;
    store_data = sd; rd = r; mem_rdata = rdat;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (rf_write_enable) begin
        obs_rfwe++;
        obs_rf_addr = rf_addr_3;
        obs_rf_data = rf_write_data;
      end
      if (mem_req) begin
        obs_req++;
        obs_addr = mem_addr; obs_wstrb = mem_wstrb; obs_wdata = mem_wdata; obs_we = mem_we;
        mem_ack = (ack_at != 0) && (obs_req == ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      if (done) begin
        obs_lat = n; obs_fault = fault; obs_done = 1'b1;
        break;
      end
    end
    mem_ack = 1'b0;
    if (!obs_done) begin
      checks++; errors++;
      $display("FAIL done_wait: no done within 60 cycles, required done");
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = '0; base = '0;
    offset = '0; store_data = '0; rd = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, fault, mem_req, mem_we, rf_write_enable} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {busy, done, fault, mem_req, mem_we, rf_write_enable});
    end
    checks++;
    if ({mem_addr, mem_wstrb, mem_wdata, rf_addr_3, rf_write_data} !== 105'b0) begin
      errors++;
      $display("FAIL reset_data: addr %h wstrb %b wdata %h rfa %0d rfd %h required all 0",
               mem_addr, mem_wstrb, mem_wdata, rf_addr_3, rf_write_data);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_load_word;
    sbq.push_back(mk(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h1004, 4'b0000, 32'h0, 1'b0, 1, 2));
    run_op(1'b0, 3'b010, 32'h1000, 32'd4, 32'h0, 5'd5, 32'hDEADBEEF, 1);
    e = sbq.pop_front();
    checks++;
    if (obs_addr !== e.addr) begin
      errors++; $display("FAIL lw_addr: got %h required %h", obs_addr, e.addr);
    end
    checks++;
    if (obs_lat !== e.lat) begin
      errors++; $display("FAIL lw_latency: got %0d required %0d", obs_lat, e.lat);
    end
    checks++;
    if (obs_rfwe !== 1 || obs_rf_addr !== e.rd || obs_rf_data !== e.data) begin
      errors++; $display("FAIL lw_wb: we_cnt %0d rd %0d data %h required 1 %0d %h",
                         obs_rfwe, obs_rf_addr, obs_rf_data, e.rd, e.data);
    end
    @(negedge clk);
    checks++;
    if (rf_model[5] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_readback: got %h required deadbeef", rf_model[5]);
    end
  endtask

  task automatic test_byte_loads;
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] offs [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    sbq.push_back(mk(1'b0, 1'b1, 5'd6, 32'hFFFFFF80, 32'h2000, 4'b0, 32'h0, 1'b0, 1, 2));
    sbq.push_back(mk(1'b0, 1'b1, 5'd7, 32'h00000080, 32'h2000, 4'b0, 32'h0, 1'b0, 1, 2));
    sbq.push_back(mk(1'b0, 1'b1, 5'd8, 32'hFFFF80FF, 32'h2000, 4'b0, 32'h0, 1'b0, 1, 2));
    sbq.push_back(mk(1'b0, 1'b1, 5'd9, 32'h000080FF, 32'h2000, 4'b0, 32'h0, 1'b0, 1, 2));
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, f3s[i], 32'h2003, offs[i], 32'h0, 5'(6 + i), 32'h80FFFF7F, 1);
      e = sbq.pop_front();
      checks++;
      if (obs_rf_data !== e.data || obs_rf_addr !== e.rd || obs_rfwe !== 1) begin
        errors++; $display("FAIL load_ext[%0d]: data %h rd %0d cnt %0d required %h %0d 1",
                           i, obs_rf_data, obs_rf_addr, obs_rfwe, e.data, e.rd);
      end
      checks++;
      if (obs_addr !== e.addr) begin
        errors++; $display("FAIL load_addr[%0d]: got %h required %h", i, obs_addr, e.addr);
      end
    end
  endtask

  task automatic test_store;
    logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] eas [3] = '{32'h3001, 32'h3002, 32'h3004};
    sbq.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h3000, 4'b0010, 32'h78787878, 1'b1, 1, 2));
    sbq.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h3000, 4'b1100, 32'h56785678, 1'b1, 1, 2));
    sbq.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h3004, 4'b1111, 32'h12345678, 1'b1, 1, 2));
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, f3s[i], eas[i], 32'd0, 32'h12345678, 5'd3, 32'hFFFFFFFF, 1);
      e = sbq.pop_front();
      checks++;
      if (obs_wstrb !== e.wstrb || obs_wdata !== e.wdata || obs_we !== e.we || obs_addr !== e.addr) begin
        errors++; $display("FAIL store_bus[%0d]: strb %b data %h we %b addr %h required %b %h %b %h",
                           i, obs_wstrb, obs_wdata, obs_we, obs_addr, e.wstrb, e.wdata, e.we, e.addr);
      end
      checks++;
      if (obs_rfwe !== 0 || obs_fault !== e.fault) begin
        errors++; $display("FAIL store_rf[%0d]: we_cnt %0d fault %b required 0 0", i, obs_rfwe, obs_fault);
      end
    end
  endtask

  task automatic test_load_r0;
    sbq.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h4000, 4'b0, 32'h0, 1'b0, 1, 2));
    run_op(1'b0, 3'b010, 32'h4000, 32'd0, 32'h0, 5'd0, 32'h55AA55AA, 1);
    e = sbq.pop_front();
    checks++;
    if (obs_rfwe !== 0 || obs_lat !== e.lat || obs_fault !== e.fault) begin
      errors++; $display("FAIL load_r0: we_cnt %0d lat %0d fault %b required 0 %0d 0",
                         obs_rfwe, obs_lat, obs_fault, e.lat);
    end
  endtask

  task automatic test_timeout;
    sbq.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 32'h5000, 4'b0, 32'h0, 1'b0, 4, 5));
    sbq.push_back(mk(1'b0, 1'b1, 5'd10, 32'hA5A5A5A5, 32'h5000, 4'b0, 32'h0, 1'b0, 4, 5));
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, 3'b010, 32'h5000, 32'd0, 32'h0, 5'd10, 32'hA5A5A5A5, (i == 0) ? 0 : 4);
      e = sbq.pop_front();
      checks++;
      if (obs_req !== e.req || obs_lat !== e.lat) begin
        errors++; $display("FAIL timeout_len[%0d]: req %0d lat %0d required %0d %0d",
                           i, obs_req, obs_lat, e.req, e.lat);
      end
      checks++;
      if (obs_fault !== e.fault || obs_rfwe !== (e.rfwe ? 1 : 0)) begin
        errors++; $display("FAIL timeout_res[%0d]: fault %b we_cnt %0d required %b %0d",
                           i, obs_fault, obs_rfwe, e.fault, e.rfwe ? 1 : 0);
      end
    end
  endtask

  task automatic test_illegal;
    logic        sts [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [3] = '{3'b011, 3'b100, 3'b110};
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(mk(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 4'b0, 32'h0, 1'b0, 0, 1));
      run_op(sts[i], f3s[i], 32'h6000, 32'd0, 32'h0, 5'd11, 32'h0, 1);
      e = sbq.pop_front();
      checks++;
      if (obs_fault !== e.fault || obs_lat !== e.lat || obs_req !== e.req || obs_rfwe !== 0) begin
        errors++; $display("FAIL illegal[%0d]: fault %b lat %0d req %0d we_cnt %0d required 1 1 0 0",
                           i, obs_fault, obs_lat, obs_req, obs_rfwe);
      end
    end
  endtask

  task automatic test_misalign;
`ifdef LSU_MISALIGN_TRAP_EN
    sbq.push_back(mk(1'b1, 1'b0, 5'd12, 32'h0, 32'h0, 4'b0, 32'h0, 1'b0, 0, 1));
`else
    sbq.push_back(mk(1'b0, 1'b1, 5'd12, 32'hCAFEF00D, 32'h1000, 4'b0, 32'h0, 1'b0, 1, 2));
`endif
    run_op(1'b0, 3'b010, 32'h1000, 32'd2, 32'h0, 5'd12, 32'hCAFEF00D, 1);
    e = sbq.pop_front();
    checks++;
    if (obs_fault !== e.fault || obs_lat !== e.lat || obs_req !== e.req) begin
      errors++; $display("FAIL misalign: fault %b lat %0d req %0d required %b %0d %0d",
                         obs_fault, obs_lat, obs_req, e.fault, e.lat, e.req);
    end
    checks++;
    if (obs_rfwe !== (e.rfwe ? 1 : 0) || (e.req > 0 && obs_addr !== e.addr) ||
        (e.rfwe && obs_rf_data !== e.data)) begin
      errors++; $display("FAIL misalign_io: we_cnt %0d addr %h data %h required %0d %h %h",
                         obs_rfwe, obs_addr, obs_rf_data, e.rfwe ? 1 : 0, e.addr, e.data);
    end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int wes = 0;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h7000; offset = 32'd0; rd = 5'd13;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL midrst_access: mem_req %b required 1", mem_req);
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, fault, mem_req, mem_we, rf_write_enable, mem_addr} !== 38'b0) begin
      errors++; $display("FAIL midrst_out: ctrl %b addr %h required 0",
                         {busy, done, fault, mem_req, mem_we, rf_write_enable}, mem_addr);
    end
    reset_n = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (rf_write_enable) wes++;
    end
    mem_ack = 1'b0;
    checks++;
    if (dones !== 0 || wes !== 0) begin
      errors++; $display("FAIL midrst_after: dones %0d writes %0d required 0 0", dones, wes);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    test_reset;
    test_load_word;
    test_byte_loads;
    test_store;
    test_load_r0;
    test_timeout;
    test_illegal;
    test_misalign;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
